// File: rtl/count_seq_pkg.sv
// +------------------------------------------------------------------+
// | count_seq_pkg : state and button index constants for count_seq   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package count_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int BTN_CLR = 0;
    localparam int BTN_LDH = 1;
    localparam int BTN_LDL = 2;
    localparam int BTN_SS  = 3;

endpackage

`default_nettype wire

// File: rtl/count_seq_ctrl_btn_debounce.sv
// +------------------------------------------------------------------+
// | btn_debounce : 2-FF synchroniser, debounce and press pulse       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            press  <= 1'b0;
            // Any sample that agrees with the accepted level restarts the run
            if (sync_2 != level) begin
                if (cnt == CNT_LAST) begin
                    cnt   <= '0;
                    level <= ~level;
                    press <= ~level;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/count_seq_ctrl.sv
// +------------------------------------------------------------------+
// | count_seq_ctrl : button-driven stopwatch/timer sequencing FSM    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_Button,
    input  logic [7:0]  i_Switches,
    input  logic        i_Down,
    output logic [15:0] o_Count,
    output logic        o_Blink,
    output logic [1:0]  o_State,
    output logic        o_Dir,
    output logic        o_Expired
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] HALF      = PW'(TICK_DIV / 2);

    logic [3:0]    press;
    logic [3:0]    level;
    logic [1:0]    state;
    logic [15:0]   count;
    logic [PW-1:0] presc;
    logic          dir;
    logic          expired;
    logic          tick;
    logic          ev_clr;
    logic          ev_ss;
    logic          ev_ldh;
    logic          ev_ldl;

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn (
                .clk   (i_clk),
                .rst_n (i_rst_n),
                .din   (i_Button[b]),
                .level (level[b]),
                .press (press[b])
            );
        end
    endgenerate

    // Only the highest-priority event of a cycle survives
    always_comb begin
        ev_clr = press[BTN_CLR];
        ev_ss  = press[BTN_SS]  & ~press[BTN_CLR];
        ev_ldh = press[BTN_LDH] & ~press[BTN_SS] & ~press[BTN_CLR];
        ev_ldl = press[BTN_LDL] & ~press[BTN_LDH] & ~press[BTN_SS] & ~press[BTN_CLR];
        tick   = (presc == TICK_LAST);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            count   <= '0;
            presc   <= '0;
            dir     <= 1'b0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ev_clr) begin
                        count <= '0;
                    end else if (ev_ss) begin
                        if (!(i_Down && count == 16'd0)) begin
                            dir   <= i_Down;
                            presc <= '0;
                            state <= ST_RUN;
                        end
                    end else if (ev_ldh) begin
                        count[15:8] <= i_Switches;
                    end else if (ev_ldl) begin
                        count[7:0] <= i_Switches;
                    end
                end
                ST_RUN: begin
                    if (ev_clr) begin
                        count <= '0;
                        state <= ST_IDLE;
                    end else if (ev_ss) begin
                        state <= ST_PAUSE;
                    end else begin
                        presc <= tick ? '0 : presc + PW'(1);
                        if (tick) begin
                            if (!dir) begin
                                count <= count + 16'd1;
                            end else if (count <= 16'd1) begin
                                // A zero loaded during pause expires here without underflow
                                count   <= '0;
                                state   <= ST_DONE;
                                expired <= 1'b1;
                            end else begin
                                count <= count - 16'd1;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (ev_clr) begin
                        count <= '0;
                        state <= ST_IDLE;
                    end else if (ev_ss) begin
                        state <= ST_RUN;
                    end else if (ev_ldh) begin
                        count[15:8] <= i_Switches;
                    end else if (ev_ldl) begin
                        count[7:0] <= i_Switches;
                    end
                end
                ST_DONE: begin
                    count <= '0;
                    presc <= tick ? '0 : presc + PW'(1);
                    if (ev_clr || ev_ss) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        case (state)
            ST_IDLE:  o_Blink = 1'b1;
            ST_PAUSE: o_Blink = 1'b0;
            default:  o_Blink = (presc < HALF);
        endcase
    end

    assign o_Count   = count;
    assign o_State   = state;
    assign o_Dir     = dir;
    assign o_Expired = expired;

endmodule

`default_nettype wire

// File: tb/tb_count_seq_ctrl.sv
// +------------------------------------------------------------------+
// | tb_count_seq_ctrl : scoreboard bench for count_seq_ctrl          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_count_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  btn;
    logic [7:0]  sw;
    logic        down;
    logic [15:0] count;
    logic        blink;
    logic [1:0]  state;
    logic        dir;
    logic        expired;

    int total;
    int bad;
    logic [20:0] sb[$];
    logic [20:0] exp_v;
    logic [20:0] obs;

    count_seq_ctrl #(
        .TICK_DIV        (4),
        .DEBOUNCE_CYCLES (2)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_Button   (btn),
        .i_Switches (sw),
        .i_Down     (down),
        .o_Count    (count),
        .o_Blink    (blink),
        .o_State    (state),
        .o_Dir      (dir),
        .o_Expired  (expired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [20:0] mk(input logic [15:0] c, input logic bl,
                                       input logic [1:0] s, input logic d, input logic e);
        return {c, bl, s, d, e};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_fixed(input int idx);
        btn[idx] = 1'b1;
        cyc(7);
        btn[idx] = 1'b0;
        cyc(7);
    endtask

    task automatic wait_state(input logic [1:0] s);
        for (int i = 0; i < 40 && state !== s; i++) cyc(1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        for (int j = 0; j < 20; j++) sb.push_back(mk(16'h0, 1'b1, 2'd0, 1'b0, 1'b0));
        for (int j = 0; j < 20; j++) begin
            exp_v = sb.pop_front();
            obs   = {count, blink, state, dir, expired};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL reset_idle j=%0d actual=%h required=%h", j, obs, exp_v);
            end
            cyc(1);
        end
    endtask

    task automatic test_load_up;
        sw = 8'h12;
        press_fixed(1);
        total++;
        if (count !== 16'h1200) begin
            bad++;
            $display("FAIL load_high actual=%h required=%h", count, 16'h1200);
        end
        sw = 8'h34;
        press_fixed(2);
        total++;
        if (count !== 16'h1234) begin
            bad++;
            $display("FAIL load_low actual=%h required=%h", count, 16'h1234);
        end
        down = 1'b0;
        btn[3] = 1'b1;
        wait_state(2'd1);
        btn[3] = 1'b0;
        for (int j = 0; j <= 12; j++)
            sb.push_back(mk(16'h1234 + 16'(j / 4), (j % 4) < 2, 2'd1, 1'b0, 1'b0));
        for (int j = 0; j <= 12; j++) begin
            exp_v = sb.pop_front();
            obs   = {count, blink, state, dir, expired};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL up_count j=%0d actual=%h required=%h", j, obs, exp_v);
            end
            if (j < 12) cyc(1);
        end
    endtask

    task automatic test_down_expire;
        btn[0] = 1'b1;
        wait_state(2'd0);
        btn[0] = 1'b0;
        total++;
        if ({state, count} !== {2'd0, 16'h0}) begin
            bad++;
            $display("FAIL run_clear actual=%h required=%h", {state, count}, {2'd0, 16'h0});
        end
        cyc(8);
        down = 1'b1;
        press_fixed(3);
        total++;
        if (state !== 2'd0) begin
            bad++;
            $display("FAIL start_down_at_zero actual=%0d required=%0d", state, 0);
        end
        sw = 8'h00;
        press_fixed(1);
        sw = 8'h02;
        press_fixed(2);
        total++;
        if (count !== 16'h0002) begin
            bad++;
            $display("FAIL load_two actual=%h required=%h", count, 16'h0002);
        end
        btn[3] = 1'b1;
        wait_state(2'd1);
        btn[3] = 1'b0;
        for (int j = 0; j <= 10; j++)
            sb.push_back(mk((j < 4) ? 16'd2 : (j < 8) ? 16'd1 : 16'd0, (j % 4) < 2,
                            (j < 8) ? 2'd1 : 2'd3, 1'b1, j == 8));
        for (int j = 0; j <= 10; j++) begin
            exp_v = sb.pop_front();
            obs   = {count, blink, state, dir, expired};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL down_expire j=%0d actual=%h required=%h", j, obs, exp_v);
            end
            if (j < 10) cyc(1);
        end
        btn[3] = 1'b1;
        wait_state(2'd0);
        btn[3] = 1'b0;
        total++;
        if ({state, count} !== {2'd0, 16'h0}) begin
            bad++;
            $display("FAIL done_to_idle actual=%h required=%h", {state, count}, {2'd0, 16'h0});
        end
        cyc(8);
    endtask

    task automatic test_wrap_glitch;
        sw = 8'hFF;
        press_fixed(1);
        press_fixed(2);
        total++;
        if (count !== 16'hFFFF) begin
            bad++;
            $display("FAIL load_ffff actual=%h required=%h", count, 16'hFFFF);
        end
        down = 1'b0;
        btn[3] = 1'b1;
        wait_state(2'd1);
        btn[3] = 1'b0;
        for (int j = 0; j <= 16; j++)
            sb.push_back(mk(16'hFFFF + 16'(j / 4), (j % 4) < 2, 2'd1, 1'b0, 1'b0));
        for (int j = 0; j <= 16; j++) begin
            exp_v = sb.pop_front();
            obs   = {count, blink, state, dir, expired};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL wrap_glitch j=%0d actual=%h required=%h", j, obs, exp_v);
            end
            btn[3] = (j == 6);
            if (j < 16) cyc(1);
        end
        btn[3] = 1'b0;
    endtask

    task automatic test_pause_resume;
        // Entered right after a count step: prescaler is 0, press lands when it reads 2
        cyc(2);
        btn[3] = 1'b1;
        cyc(5);
        btn[3] = 1'b0;
        for (int j = 0; j <= 50; j++) sb.push_back(mk(16'h0004, 1'b0, 2'd2, 1'b0, 1'b0));
        for (int j = 0; j <= 50; j++) begin
            exp_v = sb.pop_front();
            obs   = {count, blink, state, dir, expired};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL pause_hold j=%0d actual=%h required=%h", j, obs, exp_v);
            end
            cyc(1);
        end
        btn[3] = 1'b1;
        wait_state(2'd1);
        btn[3] = 1'b0;
        sb.push_back(mk(16'h0004, 1'b0, 2'd1, 1'b0, 1'b0));
        sb.push_back(mk(16'h0004, 1'b0, 2'd1, 1'b0, 1'b0));
        sb.push_back(mk(16'h0005, 1'b1, 2'd1, 1'b0, 1'b0));
        for (int j = 0; j < 3; j++) begin
            exp_v = sb.pop_front();
            obs   = {count, blink, state, dir, expired};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL resume j=%0d actual=%h required=%h", j, obs, exp_v);
            end
            if (j < 2) cyc(1);
        end
    endtask

    task automatic test_back_to_back;
        btn[0] = 1'b1;
        btn[3] = 1'b1;
        wait_state(2'd0);
        btn = 4'b0000;
        total++;
        if ({state, count} !== {2'd0, 16'h0}) begin
            bad++;
            $display("FAIL clear_beats_start actual=%h required=%h", {state, count}, {2'd0, 16'h0});
        end
        cyc(8);
        sw = 8'h55;
        press_fixed(2);
        down = 1'b1;
        btn[3] = 1'b1;
        wait_state(2'd1);
        btn[3] = 1'b0;
        cyc(5);
        total++;
        if ({count, state, dir} !== {16'h0054, 2'd1, 1'b1}) begin
            bad++;
            $display("FAIL pre_reset_run actual=%h required=%h", {count, state, dir},
                     {16'h0054, 2'd1, 1'b1});
        end
        rst_n = 1'b0;
        #2;
        total++;
        if ({count, blink, state, dir, expired} !== mk(16'h0, 1'b1, 2'd0, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL async_reset actual=%h required=%h",
                     {count, blink, state, dir, expired}, mk(16'h0, 1'b1, 2'd0, 1'b0, 1'b0));
        end
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 4'b0000;
        sw    = 8'h00;
        down  = 1'b0;
        total = 0;
        bad   = 0;
        test_reset();
        test_load_up();
        test_down_expire();
        test_wrap_glitch();
        test_pause_resume();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/count_seq_ctrl.md
Name: count_seq_ctrl

Overview:
Control FSM that sequences the 16-bit seconds counter and timer datapath feeding the four-digit seven-segment display.
- Cleans the four push-buttons: synchroniser, debounce and press-edge detection.
- Runs a prescaled tick and steps the count up (stopwatch) or down (timer).
- Loads the count bytes from the switches.
- Drives a blink flag used for the decimal point.
It sits between the board I/O and the display driver, replacing ad-hoc button and counter logic in the top level.

Parameters:
TICK_DIV, 50_000_000, i_clk cycles per count step (≥2)
DEBOUNCE_CYCLES, 500_000, consecutive stable synchronised samples needed to accept a button level change (≥1)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous assert, active-low
i_Button  in  4  raw buttons: [0] clear, [1] load high byte, [2] load low byte, [3] start/pause
i_Switches  in  8  load data byte
i_Down  in  1  direction select: 0 count up, 1 count down; sampled on start
o_Count  out  16  current count, to display
o_Blink  out  1  decimal-point blink flag
o_State  out  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
o_Dir  out  1  latched direction
o_Expired  out  1  one-cycle pulse when a down-count reaches 0

Behaviour:
- Reset: one clock, i_clk; reset is asynchronous and active-low (i_rst_n). Reset values:
  - o_Count=0, o_State=IDLE, o_Dir=0, o_Expired=0, o_Blink=1.
  - Prescaler, debounce counters and debounced levels all 0.
  - Reset mid-run aborts immediately; no pending event survives.
- Button conditioning (per button):
  - 2-FF synchroniser feeds a debounce counter.
  - The debounced level flips after DEBOUNCE_CYCLES consecutive samples differ from it; any matching sample clears the counter.
  - A press event is a 1-cycle pulse when the debounced level goes 0→1. Releases generate nothing.
  - Effect appears on outputs the cycle after the event.
- Event priority within one cycle: clear > start/pause > load high > load low. Lower-priority events in that cycle are dropped.
- IDLE:
  - clear: count=0.
  - load high: count[15:8]=i_Switches. load low: count[7:0]=i_Switches.
  - start: latch o_Dir=i_Down and zero the prescaler, then go RUN. Exception: if i_Down=1 and count==0, start is ignored and the FSM stays IDLE.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps; tick is the cycle where it equals TICK_DIV-1.
  - Up, on tick: count+1, with 0xFFFF wrapping to 0x0000 and staying in RUN.
  - Down, on tick: count-1. If the new value is 0, go DONE and pulse o_Expired in the same cycle the count becomes 0.
  - start: go PAUSE, prescaler frozen. clear: count=0, go IDLE. Loads are ignored.
- PAUSE:
  - start: go RUN, prescaler resumes from its frozen value (not zeroed).
  - Loads are allowed. A load that makes count 0 while o_Dir=1 does not expire until the next tick after resume; that tick goes DONE with count held at 0 (no underflow).
  - clear: count=0, go IDLE.
- DONE:
  - count held at 0; prescaler free-runs for blink only.
  - start or clear: go IDLE. Loads are ignored.
- o_Blink:
  - IDLE: 1. PAUSE: 0.
  - RUN and DONE: 1 while prescaler < TICK_DIV/2 (integer division), else 0.
- Widths: prescaler is clog2(TICK_DIV) bits; debounce counter is clog2(DEBOUNCE_CYCLES+1) bits. All count arithmetic is modulo 2^16.

Decomposition:
- Package count_seq_pkg: state encoding constants (IDLE/RUN/PAUSE/DONE), button index constants (BTN_CLR, BTN_LDH, BTN_LDL, BTN_SS).
- One sub-module, btn_debounce: single-bit synchroniser, debounce and rise-pulse, parameterised by DEBOUNCE_CYCLES, instantiated four times.
- FSM, prescaler and count register stay in count_seq_ctrl.

Test Plan:
All scenarios use TICK_DIV=4, DEBOUNCE_CYCLES=2.
1. Reset release, no buttons → o_Count=0, o_State=0, o_Blink=1, o_Expired=0 for 20 cycles.
2. Switches=0x12, press load high; switches=0x34, press load low; i_Down=0, press start; run 12 cycles after start takes effect → o_Count steps 0x1234→0x1235→0x1236→0x1237 every 4 cycles; o_Blink pattern 1,1,0,0 repeating.
3. Load 0x0002, i_Down=1, start → count 2→1→0 on successive ticks; o_Expired is high exactly one cycle, coincident with count=0; o_State=3. Next start → o_State=0.
4. Up count from 0xFFFF → tick gives 0x0000, o_State stays 1, o_Expired stays 0. Glitch on i_Button[3] lasting 1 cycle → no event, state unchanged.
5. RUN with prescaler at 2, press start → PAUSE, o_Blink=0, count frozen for 50 cycles. Press start again → next tick arrives 1 cycle after resume.
6. Clear and start events in the same cycle during RUN → clear wins: o_Count=0, o_State=0. Assert i_rst_n low mid-RUN → outputs reach reset values immediately, without waiting for a clock edge.
